oam_dma_engine: RTL

Hardware engine for the 0xFF46 OAM DMA register. A CPU write to 0xFF46 makes it copy 160 bytes from the source page (0xXX00–0xXX9F) into OAM (0xFE00–0xFE9F). It sits upstream of the memory unit as a second bus master behind the bus arbiter. It drives the shared address, OE, WE and tri-state databus while it holds the grant.

---
 rtl/oam_dma_engine.sv | 109 ++++++++++
 1 files changed

// File: rtl/oam_dma_engine.sv
// OAM DMA engine: copies LEN bytes from page {src,00} into OAM at DST_BASE as a second bus master.
// Optional build macro DMA_ECHO_FOLD_EN folds source pages E0-FF onto C0-DF for the read address.
module oam_dma_engine #(
    parameter int          LEN      = 160,
    parameter logic [15:0] DST_BASE = 16'hFE00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dma_start,
    input  logic [7:0]  dma_src,
    input  logic        bus_gnt,
    output logic        bus_req,
    output logic [15:0] dma_addr,
    output logic        dma_oe,
    output logic        dma_we,
    inout  wire  [7:0]  databus,
    output logic        dma_active,
    output logic        dma_done
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        READ,
        WRITE,
        DONE
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(LEN - 1);

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  src_q;
    logic [7:0]  idx;
    logic [7:0]  data_q;

    // Echo pages E0-FF mirror work RAM C0-DF; the stored src_q stays unmodified.
    function automatic logic [7:0] read_page(input logic [7:0] src);
`ifdef DMA_ECHO_FOLD_EN
        return (src >= 8'hE0) ? (src - 8'h20) : src;
`else
        return src;
`endif
    endfunction

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = IDLE;
            REQ:     if (bus_gnt) state_nxt = READ;
            READ:    if (bus_gnt) state_nxt = WRITE;
            WRITE:   if (bus_gnt) state_nxt = (idx == LAST_IDX) ? DONE : READ;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // A start strobe always wins, abandoning any copy in flight.
        if (dma_start) state_nxt = REQ;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            src_q  <= 8'h00;
            idx    <= 8'h00;
            data_q <= 8'h00;
        end else begin
            state <= state_nxt;
            if (dma_start) begin
                src_q <= dma_src;
                idx   <= 8'h00;
            end else if (state == WRITE && bus_gnt) begin
                idx <= idx + 8'h01;
            end
            if (state == READ && bus_gnt) data_q <= databus;
        end
    end

    always_comb begin
        bus_req    = 1'b0;
        dma_active = 1'b0;
        dma_oe     = 1'b0;
        dma_we     = 1'b0;
        dma_done   = 1'b0;
        dma_addr   = 16'h0000;
        case (state)
            REQ: begin
                bus_req    = 1'b1;
                dma_active = 1'b1;
            end
            READ: begin
                bus_req    = 1'b1;
                dma_active = 1'b1;
                dma_addr   = {read_page(src_q), idx};
                dma_oe     = bus_gnt;
            end
            WRITE: begin
                bus_req    = 1'b1;
                dma_active = 1'b1;
                dma_addr   = DST_BASE | {8'h00, idx};
                dma_we     = bus_gnt;
            end
            DONE:    dma_done = 1'b1;
            default: ;
        endcase
    end

    assign databus = (state == WRITE && bus_gnt) ? data_q : 8'bz;

endmodule
